// File: rtl/mips_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_muldiv_pkg
// Brief    : Shared op encodings, FSM states and default width for the MDU.
// Revision : 1.0 - initial release
// ============================================================================
package mips_muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mips_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_muldiv_if
// Brief    : Core <-> multiply/divide unit request and HI/LO result bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_muldiv_if
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, opa, opb,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, opa, opb,
        output busy, done, div_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mips_div_step.sv
`default_nettype none
// ============================================================================
// Module   : mips_div_step
// Brief    : One combinational restoring-division step (one quotient bit).
// Revision : 1.0 - initial release
// ============================================================================
module mips_div_step #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] rem_i,
    input  wire logic [WIDTH-1:0] div_i,
    input  wire logic             bit_i,
    output logic      [WIDTH-1:0] rem_o,
    output logic                  q_o
);
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // rem_i < div_i always holds, so the shifted remainder fits in WIDTH+1 bits
    assign w_shifted = {rem_i, bit_i};
    assign w_trial   = w_shifted - {1'b0, div_i};
    assign q_o       = ~w_trial[WIDTH];
    assign rem_o     = q_o ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
endmodule
`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_muldiv_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mips_muldiv_if.slave   bus
);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     opa_q;
    logic                 is_div_q;
    logic                 neg_q;
    logic                 rem_neg_q;
    logic                 zero_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 div_zero_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 w_accept;
    logic                 w_signed;
    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   mul_acc_d;
    logic [2*WIDTH-1:0]   div_acc_d;
    logic [WIDTH-1:0]     w_div_rem;
    logic                 w_div_q;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    assign w_accept = bus.start && !busy_q;
    assign w_signed = !bus.op[0];
    assign w_sign_a = w_signed && bus.opa[WIDTH-1];
    assign w_sign_b = w_signed && bus.opb[WIDTH-1];
    assign w_mag_a  = w_sign_a ? (WIDTH'(0) - bus.opa) : bus.opa;
    assign w_mag_b  = w_sign_b ? (WIDTH'(0) - bus.opb) : bus.opb;

    // Shift-add: upper half accumulates, lower half shifts the multiplier out
    assign w_mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : WIDTH'(0))};
    assign mul_acc_d = {w_mul_sum, acc_q[WIDTH-1:1]};

    mips_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i (acc_q[2*WIDTH-1:WIDTH]),
        .div_i (b_q),
        .bit_i (acc_q[WIDTH-1]),
        .rem_o (w_div_rem),
        .q_o   (w_div_q)
    );
    assign div_acc_d = {w_div_rem, acc_q[WIDTH-2:0], w_div_q};

    always_comb begin
        w_prod = acc_q;
        w_quot = acc_q[WIDTH-1:0];
        w_rem  = acc_q[2*WIDTH-1:WIDTH];
        if (neg_q) begin
            w_prod = (2*WIDTH)'(0) - acc_q;
            w_quot = WIDTH'(0) - acc_q[WIDTH-1:0];
        end
        if (rem_neg_q) begin
            w_rem = WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            opa_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            zero_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        div_zero_q <= 1'b0;
                        case (bus.op)
                            OP_MTHI: hi_q <= bus.opa;
                            OP_MTLO: lo_q <= bus.opa;
                            OP_MULT, OP_MULTU: begin
                                acc_q     <= {WIDTH'(0), w_mag_b};
                                b_q       <= w_mag_a;
                                opa_q     <= bus.opa;
                                is_div_q  <= 1'b0;
                                neg_q     <= w_sign_a ^ w_sign_b;
                                rem_neg_q <= 1'b0;
                                zero_q    <= 1'b0;
                                cnt_q     <= '0;
                                busy_q    <= 1'b1;
                                state_q   <= ST_CALC;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc_q     <= {WIDTH'(0), w_mag_a};
                                b_q       <= w_mag_b;
                                opa_q     <= bus.opa;
                                is_div_q  <= 1'b1;
                                neg_q     <= w_sign_a ^ w_sign_b;
                                rem_neg_q <= w_sign_a;
                                zero_q    <= (bus.opb == WIDTH'(0));
                                cnt_q     <= '0;
                                busy_q    <= 1'b1;
                                state_q   <= ST_CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    acc_q <= is_div_q ? div_acc_d : mul_acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (!is_div_q) begin
                        hi_q <= w_prod[2*WIDTH-1:WIDTH];
                        lo_q <= w_prod[WIDTH-1:0];
                    end else if (zero_q) begin
                        hi_q <= opa_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= w_rem;
                        lo_q <= w_quot;
                    end
                    div_zero_q <= is_div_q && zero_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_muldiv_unit
// Brief    : Directed and random checks of the MDU against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_muldiv_unit;
    import mips_muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    mips_muldiv_if #(.WIDTH(32)) bus();

    mips_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: {hi, lo} straight from MIPS arithmetic semantics
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (op)
            OP_MULT:  res = 64'(sa * sb);
            OP_MULTU: res = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic run_arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int intr_at, input string tag);
        logic [63:0] exp;
        logic [31:0] hi0, lo0;
        int          n, busy_n, dones;
        exp = model(op, a, b);
        hi0 = bus.hi;
        lo0 = bus.lo;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.opa = a; bus.opb = b;
        @(negedge clk);
        bus.start = 1'b0; bus.opa = $urandom; bus.opb = $urandom;
        n = 1; busy_n = 0;
        check({tag, " div_zero_cleared"}, 32'(bus.div_zero), 32'd0);
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_n++;
            if (n == intr_at) begin
                bus.start = 1'b1; bus.op = OP_DIVU; bus.opa = 32'd9; bus.opb = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (n == 16) begin
                check({tag, " hold_hi"}, bus.hi, hi0);
                check({tag, " hold_lo"}, bus.lo, lo0);
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check({tag, " done_latency"}, 32'(n), 32'd34);
        check({tag, " busy_cycles"}, 32'(busy_n), 32'd33);
        check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, " hi"}, bus.hi, exp[63:32]);
        check({tag, " lo"}, bus.lo, exp[31:0]);
        check({tag, " div_zero"}, 32'(bus.div_zero), 32'(op[1] && (b == 0)));
        dones = 0;
        repeat (36) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check({tag, " extra_done"}, 32'(dones), 32'd0);
    endtask

    task automatic run_single(input logic [2:0] op, input logic [31:0] a, input string tag);
        logic [31:0] hi_exp, lo_exp;
        hi_exp = (op == OP_MTHI) ? a : bus.hi;
        lo_exp = (op == OP_MTLO) ? a : bus.lo;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.opa = a; bus.opb = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " hi"}, bus.hi, hi_exp);
        check({tag, " lo"}, bus.lo, lo_exp);
        check({tag, " busy"}, 32'(bus.busy), 32'd0);
        check({tag, " done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int          dones;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1;
        bus.start = 1'b0; bus.op = 3'd0; bus.opa = '0; bus.opb = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset div_zero", 32'(bus.div_zero), 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        reset = 1'b0;

        run_arith(OP_MULT,  32'hFFFF_FFFD, 32'd5,         0, "mult_neg3x5");
        run_arith(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
        run_arith(OP_DIV,   32'hFFFF_FFF9, 32'd2,         0, "div_neg7by2");
        run_arith(OP_DIVU,  32'd100,       32'd0,         0, "divu_by0");
        run_arith(OP_DIVU,  32'd100,       32'd7,         0, "divu_100by7");
        run_arith(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, "div_minby_m1");
        run_single(OP_MTHI, 32'h1234_5678, "mthi");
        run_single(OP_MTLO, 32'h9ABC_DEF0, "mtlo");
        run_single(3'b110,  32'hDEAD_BEEF, "nop110");
        run_arith(OP_MULTU, 32'd3, 32'd4, 10, "multu_ignored_start");

        // Mid-operation async reset discards the multiply
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULT; bus.opa = 32'hFFFF_1234; bus.opb = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset busy", 32'(bus.busy), 32'd0);
        check("async_reset done", 32'(bus.done), 32'd0);
        check("async_reset hi", bus.hi, 32'd0);
        check("async_reset lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("async_reset no_done", 32'(dones), 32'd0);
        run_arith(OP_MULTU, 32'd2, 32'd2, 0, "multu_after_reset");

        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 4 == 1) rb = 32'd0;
            if (i % 5 == 2) ra = 32'h8000_0000;
            if (i % 6 == 3) rb = 32'd1 + 32'($urandom_range(0, 15));
            run_arith(rop, ra, rb, 0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
